// File: rtl/fp_mul_norm_round_pkg.sv
// fp_mul_norm_round_pkg: shared single-precision constants and payload types
//   for the multiply normalize/round path (also usable by the add path).
//   Contents: field widths, bias/exponent limits, INF/QNaN encodings,
//   fp32_t packed result and s1_t normalized-mantissa payload.
package fp_mul_norm_round_pkg;
   localparam int MANT_W    = 24;
   localparam int EXP_W     = 10;
   localparam int BIAS      = 127;
   localparam int EXP_MAX   = 255;
   localparam int SP_EXP_W  = 8;
   localparam int SP_FRAC_W = 23;
   localparam logic [31:0] SP_INF  = 32'h7F80_0000;
   localparam logic [31:0] SP_QNAN = 32'h7FC0_0000;
   typedef struct packed {
      logic                 sign;
      logic [SP_EXP_W-1:0]  exp;
      logic [SP_FRAC_W-1:0] frac;
   } fp32_t;
   typedef struct packed {
      logic                    sign;
      logic                    zero;
      logic signed [EXP_W-1:0] exp;
      logic [MANT_W-1:0]       mant;
      logic                    guard;
      logic                    sticky;
   } s1_t;
endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: combinational round-to-nearest-even, exponent range check
//   and IEEE-754 single packing with flush-to-zero.
//   p        in  normalized payload {sign, zero, exp, mant, guard, sticky}
//   result   out packed {sign, exp, frac}
//   ovf      out saturated to infinity
//   unf      out flushed to zero by exponent underflow
//   inexact  out guard or sticky nonzero (cleared for exact zero operands)
module fp_round_pack
   import fp_mul_norm_round_pkg::*;
(
   input  s1_t   p,
   output fp32_t result,
   output logic  ovf,
   output logic  unf,
   output logic  inexact
);
   localparam logic signed [EXP_W-1:0] EMAX = EXP_W'(EXP_MAX);
   logic                    round_up;
   logic [MANT_W:0]         mant_r;
   logic signed [EXP_W-1:0] exp_r;
   logic [SP_FRAC_W-1:0]    frac;
   always_comb begin
      round_up = p.guard & (p.sticky | p.mant[0]);
      mant_r   = {1'b0, p.mant} + (MANT_W+1)'(round_up);
      // a carry out of the mantissa leaves 1.000..., so only the exponent moves
      exp_r    = p.exp + EXP_W'(mant_r[MANT_W]);
      frac     = mant_r[MANT_W] ? '0 : mant_r[SP_FRAC_W-1:0];
      inexact  = !p.zero & (p.guard | p.sticky);
      ovf      = !p.zero & !exp_r[EXP_W-1] & (exp_r >= EMAX);
      unf      = !p.zero & (exp_r[EXP_W-1] | (exp_r == '0));
      result   = (p.zero | unf) ? fp32_t'({p.sign, 31'b0})
               : ovf            ? fp32_t'({p.sign, 8'hFF, 23'b0})
               :                  fp32_t'({p.sign, exp_r[SP_EXP_W-1:0], frac});
   end
endmodule

// File: rtl/fp_mul_norm_round.sv
// fp_mul_norm_round: two-stage elastic normalize-and-round stage for the
//   single-precision multiplier.
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          upstream handshake
//   in_prod, in_exp            48-bit mantissa product, signed biased exponent
//   in_sign, in_zero           result sign, zero operand marker
//   out_valid/out_ready        downstream handshake
//   out_result                 packed IEEE-754 single
//   out_ovf/out_unf/out_inexact result flags
module fp_mul_norm_round
   import fp_mul_norm_round_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [2*MANT_W-1:0]     in_prod,
   input  logic signed [EXP_W-1:0] in_exp,
   input  logic                    in_sign,
   input  logic                    in_zero,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_result,
   output logic                    out_ovf,
   output logic                    out_unf,
   output logic                    out_inexact
);
   localparam int PW = 2*MANT_W;
   logic  s1_valid, s2_valid, adv, hi;
   s1_t   s1_d, s1_q;
   fp32_t rp_res, out_q;
   logic  rp_ovf, rp_unf, rp_inexact;
   assign adv        = !s2_valid | out_ready;
   assign in_ready   = !s1_valid | adv;
   assign out_valid  = s2_valid;
   assign out_result = out_q;
   // a product in [2,4) shifts right one place and bumps the exponent
   assign hi = in_prod[PW-1];
   always_comb begin
      s1_d.sign   = in_sign;
      s1_d.zero   = in_zero;
      s1_d.exp    = in_exp + EXP_W'(hi);
      s1_d.mant   = hi ? in_prod[PW-1 -: MANT_W] : in_prod[PW-2 -: MANT_W];
      s1_d.guard  = hi ? in_prod[MANT_W-1] : in_prod[MANT_W-2];
      s1_d.sticky = hi ? |in_prod[MANT_W-2:0] : |in_prod[MANT_W-3:0];
   end
   fp_round_pack u_round_pack (
      .p       (s1_q),
      .result  (rp_res),
      .ovf     (rp_ovf),
      .unf     (rp_unf),
      .inexact (rp_inexact)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid    <= 1'b0;
         s2_valid    <= 1'b0;
         out_q       <= '0;
         out_ovf     <= 1'b0;
         out_unf     <= 1'b0;
         out_inexact <= 1'b0;
      end else begin
         if (in_ready) s1_valid <= in_valid;
         if (in_valid && in_ready) s1_q <= s1_d;
         if (adv) s2_valid <= s1_valid;
         if (adv && s1_valid) begin
            out_q       <= rp_res;
            out_ovf     <= rp_ovf;
            out_unf     <= rp_unf;
            out_inexact <= rp_inexact;
         end
      end
   end
endmodule

// File: doc/fp_mul_norm_round.md
Name: fp_mul_norm_round

Overview:
- Two-stage pipelined normalize-and-round stage for single-precision floating-point multiply.
- Sits directly downstream of the 48-bit mantissa product path.
- Consumes the 48-bit product of two 24-bit mantissas (hidden bit included), a pre-biased exponent sum and a sign.
- Emits a packed IEEE-754 single result: round-to-nearest-even, flush-to-zero, valid/ready handshake on both sides.

Parameters:
- MANT_W, 24, mantissa width including hidden bit; product width is 2*MANT_W
- EXP_W, 10, signed two's-complement width of the internal exponent
- BIAS, 127, exponent bias; also the saturation boundary reference

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream presents a product
- in_ready  output  1  block accepts when in_valid & in_ready
- in_prod  input  48  mantissa product; value in [1,4) unless zero
- in_exp  input  10  signed exponent (ea+eb-BIAS), range -127..381
- in_sign  input  1  result sign (sa^sb)
- in_zero  input  1  either operand was zero
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts when out_valid & out_ready
- out_result  output  32  {sign, exp[7:0], frac[22:0]}
- out_ovf  output  1  result saturated to infinity
- out_unf  output  1  result flushed to zero by exponent underflow
- out_inexact  output  1  guard or sticky nonzero

Behaviour:
- Reset: on clk edge with rst_n=0, s1_valid=0 and s2_valid=0. out_valid=0, out_result=0, all flags 0. in_ready is 1 the cycle after reset.
- Reset mid-operation discards all in-flight data; no partial output.
- Stage 1 (normalize), registered:
  - prod[47]=1: mant=prod[47:24], guard=prod[23], sticky=|prod[22:0], exp=in_exp+1.
  - Otherwise: mant=prod[46:23], guard=prod[22], sticky=|prod[21:0], exp=in_exp.
  - sign and zero pass through.
- Stage 2 (round/pack), registered into output:
  - round_up = guard & (sticky | mant[0]).
  - mant_r = mant + round_up (25-bit). If bit 24 set: mant_r=0x800000, exp+1.
  - inexact = guard | sticky.
  - zero=1: result {sign,31'b0}, all flags 0, including inexact.
  - exp >= 255: {sign,8'hFF,23'b0}, ovf=1, inexact as computed.
  - exp <= 0: {sign,31'b0}, unf=1; no denormals.
  - Otherwise: {sign, exp[7:0], mant_r[22:0]}.
- Handshake, elastic two-entry pipeline:
  - s2 advances when !s2_valid | out_ready.
  - s1 advances into s2 under the same condition.
  - in_ready = !s1_valid | (!s2_valid | out_ready).
  - No combinational path from in_valid to out_valid.
- Latency: 2 cycles when unstalled. Throughput: 1 per cycle.
- Ordering is preserved. Outputs hold stable while out_valid & !out_ready.
- Simultaneous accept and emit in the same cycle is legal and sustains full throughput.
- in_prod with bits 47:46 both 0 and in_zero=0 is illegal input; behaviour is don't-care, no assertion in RTL.

Decomposition:
- Shared fp package holds:
  - Constants: BIAS, EXP_MAX=255, single-precision field widths, QNaN/INF encodings.
  - Typedef fp32_t as the packed struct {sign, exp, frac}.
  - Typedef for the stage-1 payload {sign, zero, exp, mant, guard, sticky}.
- One natural sub-module: fp_round_pack. It is purely combinational stage-2 logic (round, exponent range check, pack) and is reusable by the add path.

Test Plan:
- 1.5×1.5: in_prod=0x900000000000, in_exp=127, sign 0 -> after 2 cycles out_result=0x40100000, all flags 0.
- Tie to odd: in_prod=0x400000C00000, in_exp=127 -> 0x3F800002, inexact=1. Tie to even: in_prod=0x400000400000 -> 0x3F800000, inexact=1.
- Rounding carry: in_prod=0x7FFFFFC00000, in_exp=127 -> 0x40000000, inexact=1.
- Overflow: in_prod=0x800000000000, in_exp=254, sign 1 -> 0xFF800000, ovf=1. Underflow: in_prod=0x400000000000, in_exp=0 -> 0x00000000, unf=1. in_zero=1, sign 1 -> 0x80000000, no flags.
- Backpressure: hold out_ready=0 while offering 3 back-to-back inputs -> in_ready drops after 2 accepted, out_result held stable. Release -> 3 results in order on consecutive cycles, none lost or duplicated.
- Reset mid-stream: assert rst_n=0 with both stages valid -> next cycle out_valid=0, in_ready=1. Subsequent input emits normally after 2 cycles.
